uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter. It serializes one DBIT-wide word per frame onto the tx line in this order: start bit, data LSB first, optional parity bit, stop bit(s).
- Bit timing comes from the shared 16x oversampling tick s_tick. The same tick generator also feeds the receiver.
- A one-deep holding register lets the producer queue the next word while a frame is on the line, so frames go out back-to-back with no idle gap.

Parameters:
DBIT, 8, data bits per frame (5..9)
SB_TICK, 16, s_ticks in the stop phase (16/24/32 = 1/1.5/2 stop bits)
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous reset, active-high
s_tick  in  1  one-clk pulse at 16x baud rate
tx_start  in  1  write strobe for din; accepted only when tx_ready=1
din  in  DBIT  word to transmit
tx_ready  out  1  holding register empty; a write is accepted this cycle
tx_done_tick  out  1  one-clk pulse when a frame's stop phase completes
tx  out  1  serial line, registered, idle high

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - tx=1, tx_done_tick=0, tx_ready=1.
  - State IDLE, hold register empty.
  - Tick counter s=0, bit counter n=0, shift register=0.
- Accept: when tx_start && tx_ready, din is latched into hold and hold_valid is set.
  - tx_start with tx_ready=0 is ignored: word dropped, no state change.
  - tx_ready = !hold_valid.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1. s_tick is ignored.
  - If hold_valid, next cycle enter START: load the shift register from hold, compute the parity bit from the loaded word, clear hold_valid, s=0.
  - A write accepted in that same cycle sets hold_valid again (set wins over clear).
- START: tx=0. On each s_tick, s increments. On s_tick with s==15: s=0, n=0, go to DATA.
- DATA:
  - tx = shift[0].
  - On s_tick with s==15: s=0, shift right by 1.
  - If n==DBIT-1, go to PARITY when PARITY!=0, otherwise go to STOP. Else n increments.
- PARITY:
  - tx = parity bit. Even mode: XOR of the data bits. Odd mode: its inverse.
  - After 16 ticks, go to STOP.
- STOP:
  - tx=1.
  - On s_tick with s==SB_TICK-1: tx_done_tick=1 for exactly one clk.
  - If hold_valid, go directly to START (load as in IDLE, no idle cycle). Otherwise go to IDLE.
- Line timing:
  - tx is registered and changes one clk after the state/counter change that selects it.
  - The start bit begins 1–2 clks after acceptance from IDLE.
  - Each start, data and parity bit lasts exactly 16 s_ticks. Stop lasts SB_TICK s_ticks.
- Widths: s counter is clog2(max(16,SB_TICK)) bits. n counter is clog2(DBIT) bits, minimum 1. No wrap is reachable.
- s_tick held low: all counters and tx hold their values indefinitely.
- Reset mid-frame: next edge returns to reset values. tx=1, hold is discarded, and no tx_done_tick is issued.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding, shared with the receiver
  - PARITY mode constants PAR_NONE/PAR_EVEN/PAR_ODD
  - the standard SB_TICK values
- No sub-module. The baud tick generator stays outside and is shared with the receiver. Hold register, FSM and shift path live in uart_tx.

Test Plan:
All cases use an s_tick pulse every 4 clk.
- Reset behaviour: assert rst for 3 clk mid-frame -> tx=1, tx_ready=1, tx_done_tick=0 on the first edge after reset; no done pulse afterwards.
- Basic frame: DBIT=8, PARITY=0, write 0x55 -> tx bit sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks (64 clk); one tx_done_tick 160 ticks after start-bit entry.
- Back-to-back frames:
  - Write 0xA3, then write 0x0F during the A3 data phase. The second write is accepted and tx_ready drops.
  - Stop of frame 1 flows directly into the start of frame 2 with zero idle cycles.
  - Two tx_done_ticks; line decodes as A3 then 0F.
- Drop while full: with hold occupied, pulse tx_start with 0xFF -> ignored; only the two queued words appear on the line.
- Parity: PARITY=1, din=0x07 -> parity bit 1. PARITY=2, din=0x07 -> parity bit 0. Frame lengths are 176 ticks (SB_TICK=16).
- Stall and stop length:
  - Hold s_tick low for 100 clk mid-DATA -> tx stable, counters frozen; the frame resumes correctly.
  - SB_TICK=32 -> stop phase is 32 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, parity modes and standard stop lengths.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // s_ticks in the stop phase for 1, 1.5 and 2 stop bits
  localparam int unsigned SB_TICK_1   = 16;
  localparam int unsigned SB_TICK_1P5 = 24;
  localparam int unsigned SB_TICK_2   = 32;

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side handshake of the UART transmitter: write strobe, data word and status.
interface uart_tx_if #(
  parameter int unsigned DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_ready;
  logic            tx_done_tick;

  modport master (output tx_start, din, input tx_ready, tx_done_tick);
  modport slave  (input tx_start, din, output tx_ready, tx_done_tick);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one-deep holding register feeding a start/data/parity/stop
// serializer paced by the shared 16x oversampling tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = SB_TICK_1,
  parameter int unsigned PARITY  = PAR_NONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  uart_tx_if.slave   bus,
  output logic       tx
);

  localparam int unsigned SMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int unsigned SW   = $clog2(SMAX);
  localparam int unsigned NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  uart_state_t     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [DBIT-1:0] hold_q, hold_d;
  logic            hv_q, hv_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            accept, load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      hv_q    <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      hv_q    <= hv_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    hv_d    = hv_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    load    = 1'b0;
    accept  = bus.tx_start && !hv_q;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        load = hv_q;
      end
      ST_START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == NW'(DBIT - 1))
              state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            else
              n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q;
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
            load    = hv_q;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loading from hold is shared by IDLE and the stop->start chaining path
    if (load) begin
      state_d = ST_START;
      s_d     = '0;
      shift_d = hold_q;
      par_d   = (PARITY == PAR_ODD) ? ~(^hold_q) : (^hold_q);
      hv_d    = 1'b0;
    end
    if (accept) begin
      hold_d = bus.din;
      hv_d   = 1'b1;
    end
  end

  assign tx               = tx_q;
  assign bus.tx_ready     = !hv_q;
  assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four parameterisations driven side by side,
// line samples taken once per s_tick and compared against frames built from the word.
module tb_uart_tx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_tick = 1'b0;
  logic tick_en = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if #(.DBIT(8)) if0 ();
  uart_tx_if #(.DBIT(8)) if1 ();
  uart_tx_if #(.DBIT(8)) if2 ();
  uart_tx_if #(.DBIT(8)) if3 ();

  logic       tx0, tx1, tx2, tx3;
  logic [3:0] tx_v, ready_v, done_v;
  logic [3:0] start_v = '0;
  logic [7:0] din_v [4];

  assign tx_v    = {tx3, tx2, tx1, tx0};
  assign ready_v = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};
  assign done_v  = {if3.tx_done_tick, if2.tx_done_tick, if1.tx_done_tick, if0.tx_done_tick};
  assign if0.tx_start = start_v[0];
  assign if1.tx_start = start_v[1];
  assign if2.tx_start = start_v[2];
  assign if3.tx_start = start_v[3];
  assign if0.din = din_v[0];
  assign if1.din = din_v[1];
  assign if2.din = din_v[2];
  assign if3.din = din_v[3];

  uart_tx #(.DBIT(8), .SB_TICK(SB_TICK_1), .PARITY(PAR_NONE)) dut0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .bus(if0.slave), .tx(tx0));
  uart_tx #(.DBIT(8), .SB_TICK(SB_TICK_1), .PARITY(PAR_EVEN)) dut1 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .bus(if1.slave), .tx(tx1));
  uart_tx #(.DBIT(8), .SB_TICK(SB_TICK_1), .PARITY(PAR_ODD)) dut2 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .bus(if2.slave), .tx(tx2));
  uart_tx #(.DBIT(8), .SB_TICK(SB_TICK_2), .PARITY(PAR_NONE)) dut3 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .bus(if3.slave), .tx(tx3));

  int par_m [4] = '{0, 1, 2, 0};
  int sb_m  [4] = '{16, 16, 16, 32};

  logic       samp     [4][$];
  int         done_idx [4][$];
  logic [7:0] expw     [4][$];
  int         fstart[$];
  int         tests = 0;
  int         fails = 0;

  // s_tick every 4 clk while enabled
  int div = 0;
  always @(posedge clk) begin
    #1;
    if (tick_en) begin
      s_tick = (div == 3);
      div    = (div + 1) % 4;
    end else begin
      s_tick = 1'b0;
    end
  end

  // Line is recorded in the cycle after each tick, i.e. the value the ticking state drives
  logic tick_prev = 1'b0;
  always @(negedge clk) begin
    if (tick_prev)
      for (int k = 0; k < 4; k++) samp[k].push_back(tx_v[k]);
    for (int k = 0; k < 4; k++)
      if (done_v[k]) done_idx[k].push_back(samp[k].size());
    tick_prev = s_tick;
  end

  function automatic int frame_len(input int k);
    return 16 * (9 + ((par_m[k] != 0) ? 1 : 0)) + sb_m[k];
  endfunction

  function automatic logic [255:0] frame_bits(input logic [7:0] w, input int par, input int sb);
    logic [255:0] v;
    logic         pb;
    int           p;
    v  = '0;
    p  = 0;
    pb = (($countones(w) % 2) == 1) ^ (par == 2);
    for (int t = 0; t < 16; t++) begin v[p] = 1'b0; p++; end
    for (int i = 0; i < 8; i++)
      for (int t = 0; t < 16; t++) begin v[p] = w[i]; p++; end
    if (par != 0)
      for (int t = 0; t < 16; t++) begin v[p] = pb; p++; end
    for (int t = 0; t < sb; t++) begin v[p] = 1'b1; p++; end
    return v;
  endfunction

  task automatic wr(input int k, input logic [7:0] w);
    int t = 0;
    while (ready_v[k] !== 1'b1 && t < 5000) begin @(posedge clk); #1; t++; end
    tests++;
    assert (ready_v[k] === 1'b1) else begin
      fails++; $error("FAIL ready_wait dut%0d: tx_ready=%b expected 1", k, ready_v[k]);
    end
    start_v[k] = 1'b1;
    din_v[k]   = w;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    tests++;
    assert (ready_v[k] === 1'b0) else begin
      fails++; $error("FAIL accept dut%0d: tx_ready=%b expected 0", k, ready_v[k]);
    end
    expw[k].push_back(w);
  endtask

  task automatic drop(input int k, input logic [7:0] w);
    start_v[k] = 1'b1;
    din_v[k]   = w;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    tests++;
    assert (ready_v[k] === 1'b0) else begin
      fails++; $error("FAIL drop_full dut%0d: tx_ready=%b expected 0", k, ready_v[k]);
    end
  endtask

  task automatic wait_all_done();
    for (int k = 0; k < 4; k++) begin
      int t = 0;
      while (done_idx[k].size() < expw[k].size() && t < 20000) begin @(posedge clk); t++; end
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int k = 0; k < 4; k++) begin
      samp[k].delete();
      done_idx[k].delete();
      expw[k].delete();
    end
  endtask

  task automatic check_dut(input int k);
    logic [255:0] obs, ex;
    int len, idx, st, dn, zeros;
    fstart.delete();
    idx = 0;
    len = frame_len(k);
    for (int f = 0; f < expw[k].size(); f++) begin
      ex = frame_bits(expw[k][f], par_m[k], sb_m[k]);
      while (idx < samp[k].size() && samp[k][idx] === 1'b1) idx++;
      st  = idx;
      obs = '0;
      for (int i = 0; i < len; i++) begin
        obs[i] = (idx < samp[k].size()) ? samp[k][idx] : 1'bx;
        idx++;
      end
      fstart.push_back(st);
      tests++;
      assert (obs === ex) else begin
        fails++; $error("FAIL frame dut%0d word%0d: line=%h expected %h", k, f, obs, ex);
      end
      dn = (f < done_idx[k].size()) ? done_idx[k][f] : -1;
      tests++;
      assert (dn === st + len) else begin
        fails++; $error("FAIL done_time dut%0d word%0d: tick=%0d expected %0d", k, f, dn, st + len);
      end
    end
    tests++;
    assert (done_idx[k].size() === expw[k].size()) else begin
      fails++; $error("FAIL done_count dut%0d: %0d expected %0d", k, done_idx[k].size(), expw[k].size());
    end
    zeros = 0;
    for (int i = idx; i < samp[k].size(); i++) if (samp[k][i] !== 1'b1) zeros++;
    tests++;
    assert (zeros === 0) else begin
      fails++; $error("FAIL extra_line dut%0d: %0d non-idle samples expected 0", k, zeros);
    end
  endtask

  initial begin
    logic [3:0] held;
    int         diff;
    for (int k = 0; k < 4; k++) din_v[k] = '0;
    tick_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    assert (tx_v === 4'hF && ready_v === 4'hF && done_v === 4'h0) else begin
      fails++; $error("FAIL reset_init: tx=%b ready=%b done=%b expected 1111 1111 0000", tx_v, ready_v, done_v);
    end
    rst = 1'b0;

    // Reset mid-frame with the holding register occupied
    for (int k = 0; k < 4; k++) wr(k, 8'h3C);
    for (int k = 0; k < 4; k++) wr(k, 8'h5A);
    repeat (200) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    assert (tx_v === 4'hF) else begin
      fails++; $error("FAIL reset_tx: tx=%b expected 1111", tx_v);
    end
    tests++;
    assert (ready_v === 4'hF) else begin
      fails++; $error("FAIL reset_ready: tx_ready=%b expected 1111", ready_v);
    end
    tests++;
    assert (done_v === 4'h0) else begin
      fails++; $error("FAIL reset_done: tx_done_tick=%b expected 0000", done_v);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_all();
    repeat (1500) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check_dut(k);
    clear_all();

    // Single frame of 0x55
    for (int k = 0; k < 4; k++) wr(k, 8'h55);
    wait_all_done();
    for (int k = 0; k < 4; k++) check_dut(k);
    clear_all();

    // Back-to-back: second word queued during data phase, third dropped while full
    for (int k = 0; k < 4; k++) wr(k, 8'hA3);
    repeat (150) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) wr(k, 8'h0F);
    for (int k = 0; k < 4; k++) drop(k, 8'hFF);
    wait_all_done();
    for (int k = 0; k < 4; k++) begin
      check_dut(k);
      tests++;
      assert (fstart.size() == 2 && fstart[1] === fstart[0] + frame_len(k)) else begin
        fails++; $error("FAIL back_to_back dut%0d: gap start2=%0d expected %0d", k,
                        (fstart.size() == 2) ? fstart[1] : -1, (fstart.size() > 0) ? fstart[0] + frame_len(k) : -1);
      end
    end
    clear_all();

    // Parity words 0x07 on every instance
    for (int k = 0; k < 4; k++) wr(k, 8'h07);
    wait_all_done();
    for (int k = 0; k < 4; k++) check_dut(k);
    clear_all();

    // Tick stall mid-data: line must hold, frame must resume intact
    for (int k = 0; k < 4; k++) wr(k, 8'($urandom));
    repeat (300) @(posedge clk);
    #1 tick_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    held = tx_v;
    diff = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_v !== held) diff++;
    end
    tests++;
    assert (diff === 0) else begin
      fails++; $error("FAIL stall_hold: %0d line changes expected 0", diff);
    end
    @(posedge clk); #1 tick_en = 1'b1;
    wait_all_done();
    for (int k = 0; k < 4; k++) check_dut(k);
    clear_all();

    // Random words written as fast as tx_ready allows
    repeat (4) for (int k = 0; k < 4; k++) wr(k, 8'($urandom));
    wait_all_done();
    for (int k = 0; k < 4; k++) check_dut(k);
    clear_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
